// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: passes non-memory results through, runs one
// req/ack bus transaction per load/store while stalling the pipeline.
module mem_lsu #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_err_o
);
  localparam int NUM_LANES = 4;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rdata_q;
  logic               is_load, is_store, is_byte, is_half, is_word, is_mem;
  logic               launch, tmo;
  logic [3:0]         sel_c;
  logic [31:0]        st_data;
  logic [31:0]        ld_data;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP: begin is_load  = 1'b1; is_byte = 1'b1; end
      EXE_LH_OP, EXE_LHU_OP: begin is_load  = 1'b1; is_half = 1'b1; end
      EXE_LW_OP:             begin is_load  = 1'b1; is_word = 1'b1; end
      EXE_SB_OP:             begin is_store = 1'b1; is_byte = 1'b1; end
      EXE_SH_OP:             begin is_store = 1'b1; is_half = 1'b1; end
      EXE_SW_OP:             begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misalign_o = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
  assign launch     = (state_q == IDLE) & is_mem & ~misalign_o;
  assign tmo        = (state_q == REQ) & ~bus_ack_i & (cnt_q == CNT_W'(TIMEOUT - 1));

  // Big-endian lanes: address offset 0 is the most significant byte.
  always_comb begin
    sel_c = 4'b1111;
    if (is_byte)      sel_c = 4'b1000 >> mem_addr_i[1:0];
    else if (is_half) sel_c = mem_addr_i[1] ? 4'b0011 : 4'b1100;
  end

  // Each byte lane picks its replicated slice of the store operand.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign st_data[k*8 +: 8] = is_byte ? reg2_i[7:0] :
                               is_half ? reg2_i[(k%2)*8 +: 8] :
                                         reg2_i[k*8 +: 8];
  end

  always_comb begin
    case (mem_addr_i[1:0])
      2'b00:   ld_byte = rdata_q[31:24];
      2'b01:   ld_byte = rdata_q[23:16];
      2'b10:   ld_byte = rdata_q[15:8];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = mem_addr_i[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (aluop_i)
      EXE_LB_OP:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      EXE_LBU_OP: ld_data = {24'h0, ld_byte};
      EXE_LH_OP:  ld_data = {{16{ld_half[15]}}, ld_half};
      EXE_LHU_OP: ld_data = {16'h0, ld_half};
      default:    ld_data = rdata_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    stallreq_o = 1'b0;
    wd_o       = wd_i;
    wreg_o     = 1'b0;
    wdata_o    = 32'h0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          stallreq_o = 1'b1;
          state_d    = REQ;
        end else if (!is_mem) begin
          wreg_o  = wreg_i;
          wdata_o = wdata_i;
        end
      end
      REQ: begin
        stallreq_o = 1'b1;
        if (bus_ack_i || tmo) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        // bus_err_o is high only in the DONE cycle of an aborted access.
        if (is_load && !bus_err_o) begin
          wreg_o  = wreg_i;
          wdata_o = ld_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rdata_q     <= 32'h0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_sel_o   <= 4'h0;
      bus_wdata_o <= 32'h0;
      bus_err_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_o <= 1'b0;
      if (launch) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= is_store;
        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
        bus_sel_o   <= sel_c;
        bus_wdata_o <= st_data;
        cnt_q       <= '0;
      end else if (state_q == REQ) begin
        if (bus_ack_i) begin
          rdata_q   <= bus_rdata_i;
          bus_req_o <= 1'b0;
        end else if (tmo) begin
          bus_req_o <= 1'b0;
          bus_err_o <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a bus responder with configurable wait states and
// a scoreboard of expected write-back results popped in each DONE cycle.
module tb_mem_lsu;
  localparam logic [7:0] OP_OR  = 8'b0010_0101;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  aluop_i = 8'h0;
  logic [31:0] mem_addr_i = 32'h0, reg2_i = 32'h0, wdata_i = 32'h0, bus_rdata_i = 32'h0;
  logic [4:0]  wd_i = 5'h0;
  logic        wreg_i = 1'b0, bus_ack_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o, bus_req_o, bus_we_o, stallreq_o, misalign_o, bus_err_o;
  logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;

  typedef struct packed { logic [31:0] wdata; logic wreg; } wb_t;
  wb_t sb_q[$];

  int n_chk = 0, n_fail = 0;

  mem_lsu #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .stallreq_o(stallreq_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nop();
    aluop_i = OP_OR; mem_addr_i = 32'h0; reg2_i = 32'h0; wreg_i = 1'b0; wdata_i = 32'h0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge in IDLE.
  task automatic mem_txn(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] r2, input logic [4:0] wd, input int ack_dly,
                         input logic [31:0] rdata, input logic [3:0] exp_sel,
                         input logic [31:0] exp_bwd, input int exp_stall, input logic exp_err);
    int stall, reqc, w;
    bit done;
    wb_t e;
    aluop_i = op; mem_addr_i = addr; reg2_i = r2; wd_i = wd; wreg_i = 1'b1; wdata_i = 32'h5555_5555;
    #1;
    check({tag, " idle_stall"}, 32'(stallreq_o), 32'd1);
    stall = 1; reqc = 0; w = 0; done = 0;
    @(posedge clk); @(negedge clk);
    check({tag, " req"},  32'(bus_req_o), 32'd1);
    check({tag, " addr"}, bus_addr_o, {addr[31:2], 2'b00});
    check({tag, " sel"},  32'(bus_sel_o), 32'(exp_sel));
    check({tag, " we"},   32'(bus_we_o), 32'(op[3]));
    if (op[3]) check({tag, " bwdata"}, bus_wdata_o, exp_bwd);
    check({tag, " req_wreg"}, 32'(wreg_o), 32'd0);
    for (int i = 0; i < 300 && !done; i++) begin
      if (stallreq_o) begin
        stall++; reqc++;
        bus_ack_i = (ack_dly >= 0) && (w == ack_dly);
        bus_rdata_i = rdata;
        w++;
        @(posedge clk); #1 bus_ack_i = 1'b0; bus_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk);
      end else done = 1;
    end
    if (!done) check({tag, " done_timeout"}, 32'd0, 32'd1);
    check({tag, " stall_cycles"}, 32'(stall), 32'(exp_stall));
    check({tag, " done_req"}, 32'(bus_req_o), 32'd0);
    check({tag, " done_err"}, 32'(bus_err_o), 32'(exp_err));
    check({tag, " wd"}, 32'(wd_o), 32'(wd));
    if (sb_q.size() == 0) check({tag, " sb_empty"}, 32'd0, 32'd1);
    else begin
      e = sb_q.pop_front();
      check({tag, " wdata"}, wdata_o, e.wdata);
      check({tag, " wreg"},  32'(wreg_o), 32'(e.wreg));
    end
    // Ack in DONE must be ignored.
    bus_ack_i = 1'b1;
    nop();
    @(posedge clk); #1 bus_ack_i = 1'b0;
    @(negedge clk);
    check({tag, " post_err"}, 32'(bus_err_o), 32'd0);
    check({tag, " post_req"}, 32'(bus_req_o), 32'd0);
    check({tag, " post_stall"}, 32'(stallreq_o), 32'd0);
  endtask

  task automatic push(input logic [31:0] wd, input logic wr);
    wb_t e;
    e.wdata = wd; e.wreg = wr;
    sb_q.push_back(e);
  endtask

  initial begin
    nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst bus_req",   32'(bus_req_o), 32'd0);
    check("rst bus_we",    32'(bus_we_o), 32'd0);
    check("rst bus_addr",  bus_addr_o, 32'd0);
    check("rst bus_sel",   32'(bus_sel_o), 32'd0);
    check("rst bus_wdata", bus_wdata_o, 32'd0);
    check("rst bus_err",   32'(bus_err_o), 32'd0);
    rst = 1'b0;

    // Non-memory pass-through
    aluop_i = OP_OR; wdata_i = 32'h1234; wreg_i = 1'b1; wd_i = 5'd3;
    #1;
    check("pass wdata", wdata_o, 32'h1234);
    check("pass wreg",  32'(wreg_o), 32'd1);
    check("pass wd",    32'(wd_o), 32'd3);
    check("pass stall", 32'(stallreq_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pass bus_req", 32'(bus_req_o), 32'd0);
    end

    push(32'hDEAD_BEEF, 1'b1);
    mem_txn("lw_wait", OP_LW, 32'h100, 32'h0, 5'd4, 2, 32'hDEAD_BEEF, 4'b1111, 32'h0, 4, 1'b0);
    push(32'hFFFF_FF80, 1'b1);
    mem_txn("lb", OP_LB, 32'h101, 32'h0, 5'd5, 0, 32'h1280_3456, 4'b0100, 32'h0, 2, 1'b0);
    push(32'h0000_0080, 1'b1);
    mem_txn("lbu", OP_LBU, 32'h101, 32'h0, 5'd6, 0, 32'h1280_3456, 4'b0100, 32'h0, 2, 1'b0);
    push(32'hFFFF_FFFF, 1'b1);
    mem_txn("lb3", OP_LB, 32'h103, 32'h0, 5'd7, 1, 32'h0000_00FF, 4'b0001, 32'h0, 3, 1'b0);
    push(32'hFFFF_8001, 1'b1);
    mem_txn("lh", OP_LH, 32'h102, 32'h0, 5'd8, 0, 32'h1234_8001, 4'b0011, 32'h0, 2, 1'b0);
    push(32'h0000_8001, 1'b1);
    mem_txn("lhu", OP_LHU, 32'h100, 32'h0, 5'd9, 0, 32'h8001_1234, 4'b1100, 32'h0, 2, 1'b0);
    push(32'h0, 1'b0);
    mem_txn("sh", OP_SH, 32'h102, 32'hAAAA_5678, 5'd10, 0, 32'h0, 4'b0011, 32'h5678_5678, 2, 1'b0);
    push(32'h0, 1'b0);
    mem_txn("sb", OP_SB, 32'h103, 32'h1122_3344, 5'd11, 0, 32'h0, 4'b0001, 32'h4444_4444, 2, 1'b0);
    push(32'h0, 1'b0);
    mem_txn("sw", OP_SW, 32'h104, 32'hCAFE_F00D, 5'd12, 1, 32'h0, 4'b1111, 32'hCAFE_F00D, 3, 1'b0);

    // Misaligned accesses never reach the bus
    aluop_i = OP_LW; mem_addr_i = 32'h101; wreg_i = 1'b1; wd_i = 5'd13;
    #1;
    check("mis lw flag",  32'(misalign_o), 32'd1);
    check("mis lw stall", 32'(stallreq_o), 32'd0);
    check("mis lw wreg",  32'(wreg_o), 32'd0);
    @(negedge clk);
    check("mis lw req",   32'(bus_req_o), 32'd0);
    aluop_i = OP_LH; mem_addr_i = 32'h103;
    #1;
    check("mis lh flag",  32'(misalign_o), 32'd1);
    aluop_i = OP_SH; mem_addr_i = 32'h102;
    #1;
    check("al sh flag",   32'(misalign_o), 32'd0);
    nop();
    @(negedge clk);
    check("mis req2",     32'(bus_req_o), 32'd0);

    // Timeout: 4 REQ cycles with no ack, then DONE with bus_err pulse
    push(32'h0, 1'b0);
    mem_txn("sw_tmo", OP_SW, 32'h108, 32'h0BAD_F00D, 5'd14, -1, 32'h0, 4'b1111, 32'h0BAD_F00D, 5, 1'b1);
    push(32'h0, 1'b0);
    mem_txn("lw_tmo", OP_LW, 32'h10C, 32'h0, 5'd15, -1, 32'h1111_2222, 4'b1111, 32'h0, 5, 1'b1);

    // Reset mid-transaction
    aluop_i = OP_LW; mem_addr_i = 32'h200; wreg_i = 1'b1; wd_i = 5'd16;
    @(posedge clk); @(negedge clk);
    check("rstmid req_before", 32'(bus_req_o), 32'd1);
    rst = 1'b1; nop();
    @(posedge clk); @(negedge clk);
    check("rstmid req_after", 32'(bus_req_o), 32'd0);
    check("rstmid stall",     32'(stallreq_o), 32'd0);
    rst = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h7777_7777;
    @(posedge clk); #1 bus_ack_i = 1'b0;
    @(negedge clk);
    check("rstmid late_ack req", 32'(bus_req_o), 32'd0);
    check("rstmid late_ack err", 32'(bus_err_o), 32'd0);
    push(32'h0BEE_F123, 1'b1);
    mem_txn("lw_after_rst", OP_LW, 32'h204, 32'h0, 5'd17, 0, 32'h0BEE_F123, 4'b1111, 32'h0, 2, 1'b0);

    check("sb drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end
endmodule
